// File: rtl/hex_count_pkg.sv
// Shared types and helpers for the hex display count controller.
package hex_count_pkg;

    // Run/pause state of the counter.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    // Button bit positions within btn_n_in.
    localparam int BTN_RUN = 0;
    localparam int BTN_DIR = 1;
    localparam int BTN_CLR = 2;
    localparam int NUM_BTN = 3;

    // Clock cycles spanning a duration given in milliseconds.
    function automatic int cycles_from_ms(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Clock cycles per period of a rate given in Hz.
    function automatic int cycles_from_hz(input int clk_hz, input int hz);
        return clk_hz / hz;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on an accepted 1->0 (active-low press) transition.
module btn_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    logic             stable_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             press_nxt_s;

    // Bring the asynchronous pin into the clock domain (idle level is released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DB_CYC consecutive differing samples.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        press_nxt_s  = 1'b0;
        if (sync2_r == stable_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stable_nxt_s = sync2_r;
            cnt_nxt_s    = {CNT_W{1'b0}};
            press_nxt_s  = ~sync2_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            press_r  <= 1'b0;
        end else begin
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
            press_r  <= press_nxt_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/hex_count_ctrl.sv
// Control stage for the two-digit hex display counter: debounced buttons,
// run/pause FSM, tick prescaler and the stepped up/down count datapath.
// Optional build macro HEX_COUNT_STEP_EN: while paused, the direction button
// performs a single manual count update instead of toggling direction.
module hex_count_ctrl
    import hex_count_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int TICK_HZ     = 1,
    parameter int DEBOUNCE_MS = 20,
    parameter int WIDTH       = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [2:0]       btn_n_in,
    input  logic [3:0]       sw_in,
    output logic [WIDTH-1:0] count_out,
    output logic             running_out,
    output logic             dir_up_out,
    output logic             tick_out,
    output logic             wrap_out
);

    localparam int DB_CYC   = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
    localparam int TICK_CYC = cycles_from_hz(CLK_HZ, TICK_HZ);
    localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);

    logic [NUM_BTN-1:0] press_s;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               running_r;
    logic               dir_up_r;
    logic [WIDTH-1:0]   count_r;
    logic               tick_r;
    logic               wrap_r;
    logic [PRE_W-1:0]   presc_r;

    logic               tick_s;
    logic               clr_s;
    logic               manual_step_s;
    logic               dir_toggle_s;
    logic               update_s;
    logic [WIDTH-1:0]   step_s;
    logic [WIDTH:0]     sum_s;

    logic [WIDTH-1:0]   count_nxt_s;
    logic               tick_nxt_s;
    logic               wrap_nxt_s;
    logic               dir_nxt_s;
    logic [PRE_W-1:0]   presc_nxt_s;

    for (genvar i = 0; i < NUM_BTN; i++) begin : gen_db
        btn_debounce #(
            .DB_CYC (DB_CYC)
        ) u_db (
            .clk   (clk_in),
            .rst_n (rst_n_in),
            .btn_n (btn_n_in[i]),
            .press (press_s[i])
        );
    end

    assign tick_s = (state_r == RUN) && (presc_r == PRE_LAST);
    assign clr_s  = press_s[BTN_CLR];

`ifdef HEX_COUNT_STEP_EN
    assign manual_step_s = (state_r == PAUSED) && press_s[BTN_DIR];
    assign dir_toggle_s  = (state_r == RUN) && press_s[BTN_DIR];
`else
    assign manual_step_s = 1'b0;
    assign dir_toggle_s  = press_s[BTN_DIR];
`endif

    assign update_s = tick_s || manual_step_s;

    // Step size from the switches; a zero setting still advances by one.
    always_comb begin
        step_s = {WIDTH{1'b0}};
        if (sw_in == 4'd0) begin
            step_s = WIDTH'(1);
        end else begin
            step_s = WIDTH'(sw_in);
        end
    end

    // Extended add/subtract; the top bit is the carry (up) or borrow (down).
    always_comb begin
        sum_s = {(WIDTH+1){1'b0}};
        if (dir_up_r) begin
            sum_s = {1'b0, count_r} + {1'b0, step_s};
        end else begin
            sum_s = {1'b0, count_r} - {1'b0, step_s};
        end
    end

    // Run/pause next state: the run button toggles in either state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (press_s[BTN_RUN]) begin
                    state_nxt_s = PAUSED;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAUSED: begin
                if (press_s[BTN_RUN]) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Count, direction and prescaler next values; clear overrides any update.
    always_comb begin
        count_nxt_s = count_r;
        tick_nxt_s  = 1'b0;
        wrap_nxt_s  = 1'b0;
        dir_nxt_s   = dir_up_r;
        presc_nxt_s = presc_r;

        if (clr_s) begin
            count_nxt_s = {WIDTH{1'b0}};
            tick_nxt_s  = 1'b1;
            wrap_nxt_s  = 1'b0;
        end else if (update_s) begin
            count_nxt_s = sum_s[WIDTH-1:0];
            tick_nxt_s  = 1'b1;
            wrap_nxt_s  = sum_s[WIDTH];
        end else begin
            count_nxt_s = count_r;
        end

        if (dir_toggle_s) begin
            dir_nxt_s = ~dir_up_r;
        end else begin
            dir_nxt_s = dir_up_r;
        end

        // Resuming from pause starts at zero so a full period precedes the first tick.
        if ((state_r != RUN) || (state_nxt_s != RUN) || clr_s || tick_s) begin
            presc_nxt_s = {PRE_W{1'b0}};
        end else begin
            presc_nxt_s = presc_r + PRE_W'(1);
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= RUN;
            running_r <= 1'b1;
            dir_up_r  <= 1'b1;
            count_r   <= {WIDTH{1'b0}};
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
            presc_r   <= {PRE_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == RUN);
            dir_up_r  <= dir_nxt_s;
            count_r   <= count_nxt_s;
            tick_r    <= tick_nxt_s;
            wrap_r    <= wrap_nxt_s;
            presc_r   <= presc_nxt_s;
        end
    end

    assign count_out   = count_r;
    assign running_out = running_r;
    assign dir_up_out  = dir_up_r;
    assign tick_out    = tick_r;
    assign wrap_out    = wrap_r;

endmodule
